// File: rtl/instruction_encode_loader.sv
// Assembles RV32I instruction words from opcode/field bundles and writes them sequentially into instruction memory.
// Optional build macro IMM_RANGE_CHECK_EN: reject immediates that do not fit their encoding field instead of truncating.
module instruction_encode_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [6:0]            opcode,
  input  logic [2:0]            func_3,
  input  logic                  func_7_bit_6,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           immediate,
  output logic                  imem_write_enable,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [31:0]           imem_write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   instruction_count
);

  // state   | meaning
  // S_IDLE  | after reset, waiting for start
  // S_LOAD  | session open, accepting field bundles
  // S_WRITE | encoded word on the imem write port for one cycle
  // S_DONE  | session closed (last word, full, or last on a rejected bundle)
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(BASE_ADDR);

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  generate
    if (DEPTH > (2 ** ADDR_WIDTH)) begin : g_depth_check
      $error("DEPTH exceeds the instruction-memory address space");
    end
  endgenerate

  state_t                state_q;
  state_t                state_nxt;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_inc;
  logic [31:0]           data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  last_q;
  logic                  error_q;

  logic [31:0]           enc_data;
  logic                  fmt_ok;
  logic                  imm_ok;
  logic                  is_shift;
  logic                  accept;
  logic                  reject;

  assign is_shift  = (opcode == OP_IMM) && ((func_3 == 3'b001) || (func_3 == 3'b101));
  assign count_inc = count_q + 1'b1;

  always_comb begin
    enc_data = 32'd0;
    fmt_ok   = 1'b1;
    case (opcode)
      OP_R:
        enc_data = {1'b0, func_7_bit_6, 5'b0, rs2, rs1, func_3, rd, opcode};
      OP_LOAD, OP_IMM, OP_JALR: begin
        if (is_shift)
          enc_data = {1'b0, func_7_bit_6, 5'b0, immediate[4:0], rs1, func_3, rd, opcode};
        else
          enc_data = {immediate[11:0], rs1, func_3, rd, opcode};
      end
      OP_STORE:
        enc_data = {immediate[11:5], rs2, rs1, func_3, immediate[4:0], opcode};
      OP_BRANCH:
        enc_data = {immediate[12], immediate[10:5], rs2, rs1, func_3,
                    immediate[4:1], immediate[11], opcode};
      OP_AUIPC, OP_LUI:
        enc_data = {immediate[31:12], rd, opcode};
      OP_JAL:
        enc_data = {immediate[20], immediate[10:1], immediate[11], immediate[19:12], rd, opcode};
      default:
        fmt_ok = 1'b0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Signed fit is tested by requiring all bits above the field's sign bit to replicate it.
  always_comb begin
    imm_ok = 1'b1;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        if (is_shift)
          imm_ok = (immediate[31:5] == 27'd0);
        else
          imm_ok = (immediate[31:11] == {21{immediate[11]}});
      end
      OP_STORE:
        imm_ok = (immediate[31:11] == {21{immediate[11]}});
      OP_BRANCH:
        imm_ok = (immediate[31:12] == {20{immediate[12]}}) && !immediate[0];
      OP_AUIPC, OP_LUI:
        imm_ok = (immediate[11:0] == 12'd0);
      OP_JAL:
        imm_ok = (immediate[31:20] == {12{immediate[20]}}) && !immediate[0];
      default:
        imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign accept = in_valid && in_ready;
  assign reject = !fmt_ok || !imm_ok;

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:
        if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (count_q >= DEPTH_C)
          state_nxt = S_DONE;
        else if (accept) begin
          if (reject)
            state_nxt = in_last ? S_DONE : S_LOAD;
          else
            state_nxt = S_WRITE;
        end
      end
      S_WRITE:
        state_nxt = (last_q || (count_inc == DEPTH_C)) ? S_DONE : S_LOAD;
      S_DONE:
        if (start) state_nxt = S_LOAD;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready          = 1'b0;
    imem_write_enable = 1'b0;
    busy              = 1'b0;
    done              = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready = (count_q < DEPTH_C);
        busy     = 1'b1;
      end
      S_WRITE: begin
        imem_write_enable = 1'b1;
        busy              = 1'b1;
      end
      S_DONE:
        done = 1'b1;
      default: ;
    endcase
  end

  // Address is captured at accept so a rejected bundle leaves the last written address on the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      data_q  <= 32'd0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            count_q <= '0;
            error_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (reject) begin
              error_q <= 1'b1;
            end else begin
              data_q <= enc_data;
              addr_q <= BASE_C + count_q[ADDR_WIDTH-1:0];
              last_q <= in_last;
            end
          end
        end
        S_WRITE: begin
          count_q <= count_inc;
          if ((count_inc == DEPTH_C) && !last_q)
            error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_address      = addr_q;
  assign imem_write_data   = data_q;
  assign error             = error_q;
  assign instruction_count = count_q;

endmodule
